// File: rtl/sump_pkg.sv
// Shared opcodes and controller state encoding for the SUMP command controller.
package sump_pkg;

  localparam logic [7:0] OP_RESET   = 8'h00;
  localparam logic [7:0] OP_ARM     = 8'h01;
  localparam logic [7:0] OP_ID      = 8'h02;
  localparam logic [7:0] OP_META    = 8'h04;
  localparam logic [7:0] OP_DIVIDER = 8'h80;
  localparam logic [7:0] OP_COUNTS  = 8'h81;
  localparam logic [7:0] OP_RISE    = 8'hC0;
  localparam logic [7:0] OP_FALL    = 8'hC1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_META_START,
    ST_META_WAIT,
    ST_ARMED,
    ST_CAPTURE
  } controller_state_t;

endpackage

// File: rtl/sump_watchdog.sv
// Load-on-clear down-counter; expired_o is high while enabled once the count reaches zero.
module sump_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic srst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= LOAD;
    end else if (clear_i) begin
      count_q <= LOAD;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired_o = en_i && (count_q == '0);

endmodule

// File: rtl/sump_controller.sv
// SUMP command controller: latches commands, holds configuration, sequences meta/arm/capture.
// Optional META_WAIT watchdog enabled by defining SUMP_CTRL_META_TIMEOUT_EN.
module sump_controller
  import sump_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH   = 8,
  parameter int unsigned DIVIDER_WIDTH  = 24,
  parameter int unsigned COUNT_WIDTH    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                     clock,
  input  logic                     ext_reset,
  input  logic [7:0]               opcode,
  input  logic [31:0]              command,
  input  logic                     cmd_recv_rx,
  input  logic                     run,
  input  logic                     capture_done,
  input  logic                     transmit_busy,
  input  logic                     meta_transmit_finish,
  output logic                     reset,
  output logic [DIVIDER_WIDTH-1:0] divider,
  output logic [COUNT_WIDTH-1:0]   read_count,
  output logic [COUNT_WIDTH-1:0]   delay_count,
  output logic                     data_meta_mux,
  output logic                     arm,
  output logic                     send_id,
  output logic                     begin_meta_transmit,
  output logic [SAMPLE_WIDTH-1:0]  risePattern,
  output logic [SAMPLE_WIDTH-1:0]  fallPattern,
  output logic                     meta_timeout
);

  controller_state_t        state_q;
  logic [7:0]               op_q;
  logic [31:0]              cmd_q;
  logic                     finish_seen_q;
  logic                     reset_q, mux_q, arm_q, send_id_q, begin_meta_q, meta_timeout_q;
  logic [DIVIDER_WIDTH-1:0] divider_q;
  logic [COUNT_WIDTH-1:0]   read_count_q, delay_count_q;
  logic [SAMPLE_WIDTH-1:0]  rise_q, fall_q;

  logic abort, meta_done, timeout_hit, unused_ok;

  // A reset command is the only one honoured while a flow is in progress.
  assign abort     = cmd_recv_rx && (opcode == OP_RESET) && (state_q != ST_IDLE);
  assign meta_done = (meta_transmit_finish || finish_seen_q) && !transmit_busy;
  assign unused_ok = ^{cmd_q, (TIMEOUT_CYCLES == 0)};

`ifdef SUMP_CTRL_META_TIMEOUT_EN
  sump_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk      (clock),
    .srst     (ext_reset),
    .clear_i  (state_q == ST_META_START),
    .en_i     (state_q == ST_META_WAIT),
    .expired_o(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (ext_reset) begin
      state_q        <= ST_IDLE;
      op_q           <= '0;
      cmd_q          <= '0;
      finish_seen_q  <= 1'b0;
      reset_q        <= 1'b0;
      mux_q          <= 1'b0;
      arm_q          <= 1'b0;
      send_id_q      <= 1'b0;
      begin_meta_q   <= 1'b0;
      meta_timeout_q <= 1'b0;
      divider_q      <= '0;
      read_count_q   <= '0;
      delay_count_q  <= '0;
      rise_q         <= '0;
      fall_q         <= '0;
    end else begin
      reset_q        <= 1'b0;
      begin_meta_q   <= 1'b0;
      meta_timeout_q <= 1'b0;
      if (abort) begin
        reset_q       <= 1'b1;
        arm_q         <= 1'b0;
        mux_q         <= 1'b0;
        finish_seen_q <= 1'b0;
        state_q       <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cmd_recv_rx) begin
              op_q    <= opcode;
              cmd_q   <= command;
              state_q <= ST_DECODE;
            end
          end
          ST_DECODE: begin
            state_q <= ST_IDLE;
            case (op_q)
              OP_RESET: begin
                reset_q <= 1'b1;
                arm_q   <= 1'b0;
                mux_q   <= 1'b0;
              end
              OP_ARM: begin
                arm_q   <= 1'b1;
                state_q <= ST_ARMED;
              end
              OP_ID, OP_META: begin
                send_id_q    <= (op_q == OP_ID);
                mux_q        <= 1'b0;
                begin_meta_q <= 1'b1;
                state_q      <= ST_META_START;
              end
              OP_DIVIDER: divider_q <= cmd_q[DIVIDER_WIDTH-1:0];
              OP_COUNTS: begin
                read_count_q  <= cmd_q[COUNT_WIDTH-1:0];
                delay_count_q <= cmd_q[16+COUNT_WIDTH-1:16];
              end
              OP_RISE: rise_q <= cmd_q[SAMPLE_WIDTH-1:0];
              OP_FALL: fall_q <= cmd_q[SAMPLE_WIDTH-1:0];
              default: ;
            endcase
          end
          ST_META_START: begin
            finish_seen_q <= 1'b0;
            state_q       <= ST_META_WAIT;
          end
          ST_META_WAIT: begin
            if (meta_done) begin
              finish_seen_q <= 1'b0;
              state_q       <= ST_IDLE;
            end else if (timeout_hit) begin
              finish_seen_q  <= 1'b0;
              meta_timeout_q <= 1'b1;
              mux_q          <= 1'b0;
              state_q        <= ST_IDLE;
            end else if (meta_transmit_finish) begin
              finish_seen_q <= 1'b1;
            end
          end
          ST_ARMED: begin
            if (run) begin
              arm_q   <= 1'b0;
              mux_q   <= 1'b1;
              state_q <= ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            if (capture_done) begin
              mux_q   <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign reset               = reset_q;
  assign divider             = divider_q;
  assign read_count          = read_count_q;
  assign delay_count         = delay_count_q;
  assign data_meta_mux       = mux_q;
  assign arm                 = arm_q;
  assign send_id             = send_id_q;
  assign begin_meta_transmit = begin_meta_q;
  assign risePattern         = rise_q;
  assign fallPattern         = fall_q;
  assign meta_timeout        = meta_timeout_q;

endmodule

// File: tb/tb_sump_controller.sv
// Directed bench for sump_controller: scheduled-expectation model checked every cycle plus literal pins.
module tb_sump_controller;
  import sump_pkg::*;

  localparam int SW = 32, DW = 24, CW = 16, TO = 16;

  logic          clock = 1'b0;
  logic          ext_reset = 1'b1;
  logic [7:0]    opcode = '0;
  logic [31:0]   command = '0;
  logic          cmd_recv_rx = 1'b0, run = 1'b0, capture_done = 1'b0;
  logic          transmit_busy = 1'b0, meta_transmit_finish = 1'b0;
  logic          reset, data_meta_mux, arm, send_id, begin_meta_transmit, meta_timeout;
  logic [DW-1:0] divider;
  logic [CW-1:0] read_count, delay_count;
  logic [SW-1:0] risePattern, fallPattern;

  sump_controller #(
    .SAMPLE_WIDTH(SW), .DIVIDER_WIDTH(DW), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .ext_reset(ext_reset), .opcode(opcode), .command(command),
    .cmd_recv_rx(cmd_recv_rx), .run(run), .capture_done(capture_done),
    .transmit_busy(transmit_busy), .meta_transmit_finish(meta_transmit_finish),
    .reset(reset), .divider(divider), .read_count(read_count), .delay_count(delay_count),
    .data_meta_mux(data_meta_mux), .arm(arm), .send_id(send_id),
    .begin_meta_transmit(begin_meta_transmit), .risePattern(risePattern),
    .fallPattern(fallPattern), .meta_timeout(meta_timeout)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int compared = 0, mismatched = 0, rst_seen = 0;
  bit chk_en = 1'b0;

  // Model: level outputs change at scheduled cycles; pulses are sets of cycle numbers.
  typedef struct { int at; int fld; logic [31:0] val; } upd_t;
  typedef enum { M_IDLE, M_META, M_ARMED, M_CAPTURE } mphase_t;
  upd_t        upd_q[$];
  bit          rst_at[int], bmt_at[int], to_at[int];
  logic [31:0] exp_f[8] = '{default: '0};
  string       fname[8] = '{"divider", "read_count", "delay_count", "risePattern",
                            "fallPattern", "arm", "data_meta_mux", "send_id"};
  mphase_t     mph = M_IDLE;

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, want);
    end
  endtask

  function automatic logic [31:0] act(int f);
    case (f)
      0: return 32'(divider);
      1: return 32'(read_count);
      2: return 32'(delay_count);
      3: return risePattern;
      4: return fallPattern;
      5: return 32'(arm);
      6: return 32'(data_meta_mux);
      default: return 32'(send_id);
    endcase
  endfunction

  task automatic sched(int at, int f, logic [31:0] v);
    upd_q.push_back('{at, f, v});
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      int k;
      k = 0;
      while (k < upd_q.size()) begin
        if (upd_q[k].at <= cyc) begin
          exp_f[upd_q[k].fld] = upd_q[k].val;
          upd_q.delete(k);
        end else begin
          k++;
        end
      end
      for (int f = 0; f < 8; f++) check(fname[f], act(f), exp_f[f]);
      check("reset_pulse", 32'(reset), 32'(rst_at.exists(cyc)));
      check("begin_meta_transmit", 32'(begin_meta_transmit), 32'(bmt_at.exists(cyc)));
      check("meta_timeout", 32'(meta_timeout), 32'(to_at.exists(cyc)));
      if (reset === 1'b1) rst_seen++;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Effect of one command received in cycle n, from the protocol's point of view.
  task automatic model_cmd(logic [7:0] op, logic [31:0] arg, int n);
    if (mph == M_IDLE) begin
      case (op)
        OP_RESET:   begin rst_at[n+2] = 1'b1; sched(n+2, 5, 0); sched(n+2, 6, 0); end
        OP_ARM:     begin sched(n+2, 5, 1); mph = M_ARMED; end
        OP_ID:      begin sched(n+2, 7, 1); bmt_at[n+2] = 1'b1; mph = M_META; end
        OP_META:    begin sched(n+2, 7, 0); bmt_at[n+2] = 1'b1; mph = M_META; end
        OP_DIVIDER: sched(n+2, 0, arg & 32'h00FF_FFFF);
        OP_COUNTS:  begin sched(n+2, 1, {16'h0, arg[15:0]}); sched(n+2, 2, {16'h0, arg[31:16]}); end
        OP_RISE:    sched(n+2, 3, arg);
        OP_FALL:    sched(n+2, 4, arg);
        default:    ;
      endcase
    end else if (op == OP_RESET) begin
      rst_at[n+1] = 1'b1;
      sched(n+1, 5, 0);
      sched(n+1, 6, 0);
      mph = M_IDLE;
    end
  endtask

  task automatic send_cmd(logic [7:0] op, logic [31:0] arg);
    opcode = op;
    command = arg;
    cmd_recv_rx = 1'b1;
    model_cmd(op, arg, cyc);
    tick();
    cmd_recv_rx = 1'b0;
    opcode = 8'($urandom);
    command = $urandom;
  endtask

  task automatic drive_run();
    run = 1'b1;
    sched(cyc+1, 5, 0);
    sched(cyc+1, 6, 1);
    mph = M_CAPTURE;
    tick();
    run = 1'b0;
  endtask

  int base;

  initial begin
    tick();
    chk_en = 1'b1;
    tick(2);
    check("rst_divider", 32'(divider), 32'd0);
    check("rst_arm", 32'(arm), 32'd0);
    ext_reset = 1'b0;
    tick();

    // divider load, two-cycle latency
    send_cmd(OP_DIVIDER, 32'h0000_0063);
    tick(3);
    check("lit_divider", 32'(divider), 32'd99);

    // ID flow: finish while busy holds META_WAIT, a config command meanwhile is dropped
    transmit_busy = 1'b1;
    send_cmd(OP_ID, 32'h0);
    tick();
    check("lit_begin_meta", 32'(begin_meta_transmit), 32'd1);
    check("lit_send_id", 32'(send_id), 32'd1);
    tick(2);
    meta_transmit_finish = 1'b1;
    tick();
    meta_transmit_finish = 1'b0;
    tick(2);
    send_cmd(OP_FALL, 32'h0000_00FF);
    tick(2);
    transmit_busy = 1'b0;
    tick();
    mph = M_IDLE;
    send_cmd(OP_FALL, 32'h0000_0001);
    tick(2);
    check("lit_fall", fallPattern, 32'h1);

    // counts, arm, run, capture
    send_cmd(OP_COUNTS, 32'h0040_0100);
    tick();
    send_cmd(OP_ARM, 32'h0);
    tick(2);
    check("lit_read_count", 32'(read_count), 32'h0100);
    check("lit_delay_count", 32'(delay_count), 32'h0040);
    check("lit_arm", 32'(arm), 32'd1);
    drive_run();
    tick();
    check("lit_mux_capture", 32'(data_meta_mux), 32'd1);
    capture_done = 1'b1;
    sched(cyc+1, 6, 0);
    mph = M_IDLE;
    tick();
    capture_done = 1'b0;
    tick();
    check("lit_mux_idle", 32'(data_meta_mux), 32'd0);

    // run with capture_done together in ARMED: capture_done ignored
    send_cmd(OP_ARM, 32'h0);
    tick(2);
    capture_done = 1'b1;
    drive_run();
    capture_done = 1'b0;
    tick(2);
    capture_done = 1'b1;
    sched(cyc+1, 6, 0);
    mph = M_IDLE;
    tick();
    capture_done = 1'b0;
    tick();

    // rise pattern and an unknown opcode
    send_cmd(OP_RISE, 32'hA5A5_F00F);
    tick();
    send_cmd(8'h55, 32'hFFFF_FFFF);
    tick(2);
    check("lit_rise", risePattern, 32'hA5A5_F00F);

    // ARMED ignores 0x04, then abort
    send_cmd(OP_ARM, 32'h0);
    tick(2);
    send_cmd(OP_META, 32'h0);
    tick(2);
    send_cmd(OP_RESET, 32'h0);
    tick();

    // run and abort in the same cycle: abort wins
    send_cmd(OP_ARM, 32'h0);
    tick(2);
    run = 1'b1;
    send_cmd(OP_RESET, 32'h0);
    run = 1'b0;
    tick(2);

    // abort out of META_WAIT
    transmit_busy = 1'b1;
    send_cmd(OP_META, 32'h0);
    tick(3);
    send_cmd(OP_RESET, 32'h0);
    transmit_busy = 1'b0;
    tick(2);

    // five reset commands back to back
    base = rst_seen;
    for (int i = 0; i < 5; i++) begin
      send_cmd(OP_RESET, 32'h0);
      tick();
    end
    tick(2);
    check("lit_five_pulses", 32'(rst_seen - base), 32'd5);

`ifdef SUMP_CTRL_META_TIMEOUT_EN
    // no finish: timeout pulse 16 cycles after META_WAIT entry
    to_at[cyc+19] = 1'b1;
    sched(cyc+19, 6, 0);
    send_cmd(OP_META, 32'h0);
    tick(19);
    mph = M_IDLE;
    tick(2);
    send_cmd(OP_DIVIDER, 32'h00AB_CDEF);
    tick(3);
    check("lit_after_timeout", 32'(divider), 32'h00AB_CDEF);
`endif

    tick(3);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sump_controller.md
Name: sump_controller

Overview:
- Parametrised SUMP-protocol command controller for the logic analyzer.
- Sits between the UART command decoder and the capture datapath (sampler/divider, trigger, sample memory, meta unit).
- Latches 5-byte commands and updates configuration registers: divider, read/delay counts, trigger patterns.
- Sequences three flows: ID/metadata transmission, arm→capture→dump, and abort-on-reset.

Parameters:
SAMPLE_WIDTH, 8, sample channel count; trigger pattern width (1..32)
DIVIDER_WIDTH, 24, width of sample-rate divider register (≤24)
COUNT_WIDTH, 16, width of read_count and delay_count
TIMEOUT_CYCLES, 1000000, META_WAIT watchdog limit (used only with the optional feature)

Ports:
clock  in  1  system clock
ext_reset  in  1  synchronous active-high reset
opcode  in  8  opcode from command decoder, valid with cmd_recv_rx
command  in  32  argument from command decoder, valid with cmd_recv_rx
cmd_recv_rx  in  1  single-cycle pulse: full command received
run  in  1  trigger fired
capture_done  in  1  pulse: sample memory finished dumping read_count samples
transmit_busy  in  1  UART transmitter busy
meta_transmit_finish  in  1  pulse: meta unit done
reset  out  1  datapath soft reset, one-cycle pulse
divider  out  DIVIDER_WIDTH  sample-rate divider
read_count  out  COUNT_WIDTH  samples to read back
delay_count  out  COUNT_WIDTH  post-trigger samples
data_meta_mux  out  1  0 = meta to UART, 1 = sample data to UART
arm  out  1  trigger armed (level)
send_id  out  1  1 = meta unit sends ID string, 0 = full metadata
begin_meta_transmit  out  1  one-cycle start pulse to meta unit
risePattern  out  SAMPLE_WIDTH  rising-edge trigger mask
fallPattern  out  SAMPLE_WIDTH  falling-edge trigger mask
meta_timeout  out  1  one-cycle error pulse (0 when feature compiled out)

Behaviour:
- ext_reset (synchronous, highest priority): state IDLE, latches cleared, all outputs 0.
- States: IDLE, DECODE, META_START, META_WAIT, ARMED, CAPTURE.
- IDLE: on cmd_recv_rx, latch opcode and command; next cycle DECODE. Decode never uses live opcode/command.
- DECODE, one cycle, then IDLE unless stated otherwise. Register updates are visible the cycle after DECODE.
  - 0x00: reset pulse for 1 cycle; clear arm and data_meta_mux. Config registers are retained.
  - 0x01: go ARMED.
  - 0x02: send_id=1; go META_START.
  - 0x04: send_id=0; go META_START.
  - 0x80: divider ← command[DIVIDER_WIDTH-1:0].
  - 0x81: read_count ← command[COUNT_WIDTH-1:0]; delay_count ← command[16+COUNT_WIDTH-1:16].
  - 0xC0: risePattern ← command[SAMPLE_WIDTH-1:0].
  - 0xC1: fallPattern ← command[SAMPLE_WIDTH-1:0].
  - Any other opcode: ignored, no output change.
- META_START: data_meta_mux=0; begin_meta_transmit=1 for exactly one cycle; go META_WAIT.
- META_WAIT: exit to IDLE when meta_transmit_finish has been seen AND transmit_busy=0.
  - If finish arrives while busy, remember it and wait for busy to drop.
- ARMED: arm=1. On run, drop arm next cycle, set data_meta_mux=1, go CAPTURE.
- CAPTURE: data_meta_mux=1 until capture_done, then data_meta_mux=0 and go IDLE.
- Abort: cmd_recv_rx with opcode 0x00 in any non-IDLE state gives the 0x00 action next cycle and returns to IDLE. All other commands outside IDLE are dropped.
- Simultaneous events:
  - run and an abort in the same cycle: abort wins.
  - capture_done and run in ARMED: ignore capture_done.
- Latency: cmd_recv_rx → register update or reset pulse is 2 cycles; cmd_recv_rx → begin_meta_transmit is 2 cycles.
- Every output is registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro SUMP_CTRL_META_TIMEOUT_EN.
- Defined:
  - Counter runs in META_WAIT and clears on entry.
  - Reaching TIMEOUT_CYCLES-1 gives a meta_timeout pulse for 1 cycle, data_meta_mux=0, and a return to IDLE.
- Undefined: no counter; meta_timeout tied 0; META_WAIT waits indefinitely.

Decomposition:
- Package sump_pkg holds:
  - opcode localparams (OP_RESET, OP_ARM, OP_ID, OP_META, OP_DIVIDER, OP_COUNTS, OP_RISE, OP_FALL);
  - controller_state_t enum.
- Sub-module sump_watchdog (load-on-clear down-counter, width $clog2(TIMEOUT_CYCLES)). Instantiated only under the macro.

Test Plan:
- Reset, then cmd 0x80 with command=0x00_00_0063 → divider=99 two cycles later; no other output changes.
- cmd 0x02 → send_id=1 and begin_meta_transmit pulse 2 cycles after rx; finish while transmit_busy=1 holds META_WAIT; busy→0 → IDLE next cycle.
- cmd 0x81 with 0x0040_0100 → read_count=0x0100, delay_count=0x0040. Then cmd 0x01 → arm=1; run → arm=0, data_meta_mux=1; capture_done → mux=0, IDLE.
- SAMPLE_WIDTH=32: cmd 0xC0 with 0xA5A5_F00F → risePattern=0xA5A5F00F. cmd 0xC1 with 0x0000_0001 → fallPattern=1.
- ARMED, then cmd 0x04 → ignored (still ARMED). Then cmd 0x00 → reset pulse for 1 cycle, arm=0, IDLE. Repeat 0x00 five times back-to-back → five pulses, no hang.
- With SUMP_CTRL_META_TIMEOUT_EN and TIMEOUT_CYCLES=16: cmd 0x04, no finish → meta_timeout pulse 16 cycles after META_WAIT entry, then IDLE.
